// File: rtl/sync_tx_pkg.sv
// rtl/sync_tx_pkg.sv - shared types and default constants for the sync frame link
// Purpose: FSM state type for sync_frame_tx, default sync word/widths shared with
//          the detector side, and a small elaboration-time helper.
// Ports:   none (package)
package sync_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  localparam int                        DEF_SYNC_BITS    = 4;
  localparam logic [DEF_SYNC_BITS-1:0]  DEF_SYNC_PATTERN = 4'b1101;
  localparam int                        DEF_DATA_BITS    = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// rtl/flex_pts_sr.sv - parameterised parallel-to-serial shift register, MSB first
// Purpose: holds a captured parallel word and presents it one bit at a time on
//          serial_msb; each shift moves the next lower bit into the MSB slot.
// Ports:   clk, n_rst      - clock, async active-low reset
//          load_en         - capture parallel_in (wins over shift_en)
//          shift_en        - shift left by one, zero fill
//          parallel_in     - word to capture
//          serial_msb      - current MSB of the register
module flex_pts_sr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_msb
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q <= '0;
    end else if (load_en) begin
      sr_q <= parallel_in;
    end else if (shift_en) begin
      // Shift operator keeps this legal for WIDTH == 1
      sr_q <= sr_q << 1;
    end
  end

  assign serial_msb = sr_q[WIDTH-1];

endmodule

// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - serial frame transmitter: sync word then payload, MSB first
// Purpose: on a load request in IDLE, captures data_in and sends SYNC_PATTERN
//          followed by the captured payload on a registered serial line, then
//          flags completion with a one-cycle done pulse.
// Ports:   clk         - system clock, rising edge
//          n_rst       - async active-low reset, abandons any frame in flight
//          load_en     - frame request, honoured only in IDLE
//          data_in     - payload, captured on the accepting edge
//          serial_out  - registered serial bit stream
//          busy        - high from first sync bit through the done cycle
//          done        - one-cycle pulse after the last payload bit
module sync_frame_tx
  import sync_tx_pkg::*;
#(
  parameter int                   DATA_BITS    = DEF_DATA_BITS,
  parameter int                   SYNC_BITS    = DEF_SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN = SYNC_BITS'(DEF_SYNC_PATTERN),
  parameter logic                 IDLE_LEVEL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 done
);

  localparam int                CNT_W     = $clog2(max_int(SYNC_BITS, DATA_BITS) + 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             serial_q;
  logic             busy_q;
  logic             done_q;

  logic             load_accept;
  logic             sr_shift;
  logic             sr_msb;
  logic             sync_next_bit;

  // Output register launches the bit for the *next* cycle, so in SYNC at
  // count c the next bit to present is pattern index SYNC_BITS-2-c.
  always_comb begin
    sync_next_bit = IDLE_LEVEL;
    for (int i = 0; i < SYNC_BITS - 1; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sync_next_bit = SYNC_PATTERN[SYNC_BITS-2-i];
      end
    end
  end

  assign load_accept = (state_q == IDLE) && load_en;
  // Shift whenever the payload MSB is consumed into the output register:
  // on the SYNC->DATA edge and on every DATA edge.
  assign sr_shift    = ((state_q == SYNC) && (cnt_q == SYNC_LAST)) || (state_q == DATA);

  flex_pts_sr #(
    .WIDTH (DATA_BITS)
  ) u_payload_sr (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_en     (load_accept),
    .shift_en    (sr_shift),
    .parallel_in (data_in),
    .serial_msb  (sr_msb)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          done_q   <= 1'b0;
          if (load_en) begin
            state_q  <= SYNC;
            serial_q <= SYNC_PATTERN[SYNC_BITS-1];
            busy_q   <= 1'b1;
          end else begin
            serial_q <= IDLE_LEVEL;
            busy_q   <= 1'b0;
          end
        end

        SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_q  <= DATA;
            cnt_q    <= '0;
            serial_q <= sr_msb;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            serial_q <= sync_next_bit;
          end
        end

        DATA: begin
          if (cnt_q == DATA_LAST) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            serial_q <= IDLE_LEVEL;
            done_q   <= 1'b1;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            serial_q <= sr_msb;
          end
        end

        DONE: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          serial_q <= IDLE_LEVEL;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end

        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          serial_q <= IDLE_LEVEL;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb/tb_sync_frame_tx.sv - self-checking bench for sync_frame_tx
`timescale 1ns/100ps
module tb_sync_frame_tx;
  import sync_tx_pkg::*;

  localparam realtime         CLK_PERIOD = 2.5;
  localparam int              DB         = 8;
  localparam int              SB         = 4;
  localparam logic [SB-1:0]   PAT        = 4'b1101;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          load_en;
  logic [DB-1:0] data_in;
  logic          serial_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected per-cycle output: {serial, busy, done, last_sync_bit}
  logic [3:0] exp_q[$];
  logic [3:0] cur;
  bit         check_det = 0;

  // Mealy "1101" detector fed by the serial line
  logic [2:0] hist;
  logic       det_o;

  always #(CLK_PERIOD/2) clk = ~clk;

  sync_frame_tx dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_en    (load_en),
    .data_in    (data_in),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) hist <= 3'b000;
    else        hist <= {hist[1:0], serial_out};
  end
  assign det_o = ({hist, serial_out} == 4'b1101);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // A frame is SB sync bits, DB payload bits, one done cycle, and one
  // mandatory idle cycle during which no load can be taken.
  task automatic push_frame(input logic [DB-1:0] d);
    for (int i = 0; i < SB; i++) exp_q.push_back({PAT[SB-1-i], 1'b1, 1'b0, (i == SB-1)});
    for (int i = 0; i < DB; i++) exp_q.push_back({d[DB-1-i], 1'b1, 1'b0, 1'b0});
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #0.8;
    if (!n_rst) begin
      exp_q.delete();
      cur = 4'b0000;
    end else begin
      if (exp_q.size() == 0 && load_en) push_frame(data_in);
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
    end
    chk("serial_out", serial_out, cur[3]);
    chk("busy", busy, cur[2]);
    chk("done", done, cur[1]);
    if (check_det) chk("det_o", det_o, cur[0]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #0.5;
    chk("rst_serial", serial_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    n_rst = 1'b1;
  endtask

  logic [11:0] bits;
  logic [7:0]  pay;
  int          done_cyc, busy_cnt, done_cnt, det_cnt;

  initial begin
    n_rst   = 1'b1;
    load_en = 1'b0;
    data_in = '0;
    #0.3;
    do_reset();
    for (int i = 0; i < 5; i++) tick();

    // T1: reset mid-IDLE
    do_reset();
    for (int i = 0; i < 4; i++) tick();

    // T2: basic frame with A5
    load_en = 1'b1; data_in = 8'hA5;
    bits = '0; done_cyc = 0; busy_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin load_en = 1'b0; data_in = 8'h5E; end
      if (c <= 12) bits = {bits[10:0], serial_out};
      if (done) done_cyc = c;
      if (busy) busy_cnt++;
    end
    chk("t2_bits", bits, 12'b1101_1010_0101);
    chk("t2_done_cycle", done_cyc, 13);
    chk("t2_busy_cycles", busy_cnt, 13);

    // T3: load during DATA is ignored; hold request until it is taken
    load_en = 1'b1; data_in = 8'h5A;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    load_en = 1'b1; data_in = 8'hFF;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (done) done_cnt++; end
    load_en = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (done) done_cnt++; end
    chk("t3_done_pulses", done_cnt, 2);

    // T4: data_in change after capture has no effect
    load_en = 1'b1; data_in = 8'h3C;
    pay = '0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1) begin load_en = 1'b0; data_in = 8'h00; end
      if (c >= 5 && c <= 12) pay = {pay[6:0], serial_out};
    end
    chk("t4_payload", pay, 8'h3C);

    // T5: load held high for three back-to-back frames
    load_en = 1'b1; data_in = 8'h81;
    done_cnt = 0;
    for (int i = 0; i < 42; i++) begin tick(); if (done) done_cnt++; end
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (done) done_cnt++; end
    chk("t5_done_pulses", done_cnt, 3);

    // T6: link check with downstream detector
    check_det = 1;
    load_en = 1'b1; data_in = 8'h00;
    det_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) load_en = 1'b0;
      if (det_o) det_cnt++;
    end
    check_det = 0;
    chk("t6_det_pulses", det_cnt, 1);

    // T1: reset mid-DATA abandons the frame
    load_en = 1'b1; data_in = 8'hC3;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    do_reset();
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      load_en = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset();
      else tick();
    end
    load_en = 1'b0;
    for (int i = 0; i < 16; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
